// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder
// Purpose  : Packs a mnemonic code plus register/immediate/target fields into
//            a 32-bit MIPS instruction word, then buffers the words in a small
//            valid/ready output FIFO. Illegal requests are accepted and
//            dropped, and they set a sticky err flag.
// Options  : MIPS_ENC_FIELD_CHECK_EN - when defined, a nonzero field that the
//            selected format ignores makes the request illegal. When it is
//            not defined, such fields are forced to 0.
// Revision : 1.0 - initial release
// ============================================================================
module mips_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       mnem,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic [4:0]       shamt,
    input  logic [15:0]      imm,
    input  logic [25:0]      target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err,
    output logic [CNT_W-1:0] emit_cnt
);

    localparam int           c_aw    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

`ifdef MIPS_ENC_FIELD_CHECK_EN
    localparam logic c_field_check = 1'b1;
`else
    localparam logic c_field_check = 1'b0;
`endif

    localparam logic [1:0] c_fmt_r   = 2'd0;
    localparam logic [1:0] c_fmt_i   = 2'd1;
    localparam logic [1:0] c_fmt_j   = 2'd2;
    localparam logic [1:0] c_fmt_bad = 2'd3;

    logic [1:0]  w_fmt;
    logic [5:0]  w_code;
    logic        w_keep_rs, w_keep_rt, w_keep_rd, w_keep_sh;
    logic [4:0]  w_f_rs, w_f_rt, w_f_rd, w_f_sh;
    logic [31:0] w_word;
    logic        w_ignored_nz;
    logic        w_illegal;
    logic        w_accept, w_push, w_pop;

    logic [31:0]      r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             r_err;
    logic [CNT_W-1:0] r_emit_cnt;

    // Decode the mnemonic into a format, opcode/funct, and the fields it keeps
    always_comb begin
        w_fmt     = c_fmt_bad;
        w_code    = 6'h00;
        w_keep_rs = 1'b1;
        w_keep_rt = 1'b1;
        w_keep_rd = 1'b1;
        w_keep_sh = 1'b0;
        case (mnem)
            5'd0:  begin w_fmt = c_fmt_r; w_code = 6'h20; end
            5'd1:  begin w_fmt = c_fmt_r; w_code = 6'h21; end
            5'd2:  begin w_fmt = c_fmt_r; w_code = 6'h22; end
            5'd3:  begin w_fmt = c_fmt_r; w_code = 6'h23; end
            5'd4:  begin w_fmt = c_fmt_r; w_code = 6'h24; end
            5'd5:  begin w_fmt = c_fmt_r; w_code = 6'h25; end
            5'd6:  begin w_fmt = c_fmt_r; w_code = 6'h26; end
            5'd7:  begin w_fmt = c_fmt_r; w_code = 6'h27; end
            5'd8:  begin w_fmt = c_fmt_r; w_code = 6'h2A; end
            5'd9:  begin w_fmt = c_fmt_r; w_code = 6'h2B; end
            5'd10: begin w_fmt = c_fmt_r; w_code = 6'h00; w_keep_rs = 1'b0; w_keep_sh = 1'b1; end
            5'd11: begin w_fmt = c_fmt_r; w_code = 6'h02; w_keep_rs = 1'b0; w_keep_sh = 1'b1; end
            5'd12: begin w_fmt = c_fmt_r; w_code = 6'h03; w_keep_rs = 1'b0; w_keep_sh = 1'b1; end
            5'd13: begin w_fmt = c_fmt_r; w_code = 6'h04; end
            5'd14: begin w_fmt = c_fmt_r; w_code = 6'h06; end
            5'd15: begin w_fmt = c_fmt_r; w_code = 6'h07; end
            5'd16: begin w_fmt = c_fmt_r; w_code = 6'h08; w_keep_rt = 1'b0; w_keep_rd = 1'b0; end
            5'd17: begin w_fmt = c_fmt_i; w_code = 6'h08; end
            5'd18: begin w_fmt = c_fmt_i; w_code = 6'h09; end
            5'd19: begin w_fmt = c_fmt_i; w_code = 6'h0A; end
            5'd20: begin w_fmt = c_fmt_i; w_code = 6'h0B; end
            5'd21: begin w_fmt = c_fmt_i; w_code = 6'h0C; end
            5'd22: begin w_fmt = c_fmt_i; w_code = 6'h0D; end
            5'd23: begin w_fmt = c_fmt_i; w_code = 6'h0E; end
            5'd24: begin w_fmt = c_fmt_i; w_code = 6'h0F; w_keep_rs = 1'b0; end
            5'd25: begin w_fmt = c_fmt_i; w_code = 6'h23; end
            5'd26: begin w_fmt = c_fmt_i; w_code = 6'h2B; end
            5'd27: begin w_fmt = c_fmt_i; w_code = 6'h04; end
            5'd28: begin w_fmt = c_fmt_i; w_code = 6'h05; end
            5'd29: begin w_fmt = c_fmt_j; w_code = 6'h02; end
            5'd30: begin w_fmt = c_fmt_j; w_code = 6'h03; end
            default: w_fmt = c_fmt_bad;
        endcase
    end

    assign w_f_rs = w_keep_rs ? rs    : 5'd0;
    assign w_f_rt = w_keep_rt ? rt    : 5'd0;
    assign w_f_rd = w_keep_rd ? rd    : 5'd0;
    assign w_f_sh = w_keep_sh ? shamt : 5'd0;

    // Assemble the word and flag any nonzero field the format discards
    always_comb begin
        w_word       = 32'd0;
        w_ignored_nz = 1'b0;
        case (w_fmt)
            c_fmt_r: begin
                w_word       = {6'h00, w_f_rs, w_f_rt, w_f_rd, w_f_sh, w_code};
                w_ignored_nz = (w_f_rs != rs) || (w_f_rt != rt) || (w_f_rd != rd) ||
                               (w_f_sh != shamt) || (imm != 16'd0) || (target != 26'd0);
            end
            c_fmt_i: begin
                w_word       = {w_code, w_f_rs, rt, imm};
                w_ignored_nz = (w_f_rs != rs) || (rd != 5'd0) || (shamt != 5'd0) ||
                               (target != 26'd0);
            end
            c_fmt_j: begin
                w_word       = {w_code, target};
                w_ignored_nz = (rs != 5'd0) || (rt != 5'd0) || (rd != 5'd0) ||
                               (shamt != 5'd0) || (imm != 16'd0);
            end
            default: begin
                w_word       = 32'd0;
                w_ignored_nz = 1'b0;
            end
        endcase
    end

    assign w_illegal = (w_fmt == c_fmt_bad) || (c_field_check && w_ignored_nz);

    // Full blocks acceptance outright, so a same-cycle pop cannot enable a push
    assign in_ready  = (r_count != c_depth);
    assign out_valid = (r_count != '0);
    assign out_instr = out_valid ? r_mem[r_rd_ptr] : 32'd0;
    assign err       = r_err;
    assign emit_cnt  = r_emit_cnt;

    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && !w_illegal;
    assign w_pop    = out_valid && out_ready;

    // FIFO storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers, occupancy, sticky error and emitted-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_emit_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_aw'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= (r_rd_ptr == c_aw'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                r_emit_cnt <= r_emit_cnt + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_instr_encoder
// Purpose  : Self-checking bench for mips_instr_encoder: table vectors,
//            hand sequences for backpressure/illegal/reset, and randomized
//            traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       mnem, rs, rt, rd, shamt;
    logic [15:0]      imm;
    logic [25:0]      target;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             err;
    logic [CNT_W-1:0] emit_cnt;

    int errors = 0;
    int checks = 0;

    mips_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
        .target(target), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .err(err), .emit_cnt(emit_cnt)
    );

    always #5 clk = ~clk;

    // funct codes for mnemonics 0..16, opcodes for 17..30
    localparam logic [5:0] FUNCT_TAB [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
        6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    localparam logic [5:0] OP_TAB [14] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
        6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    typedef struct {
        logic [4:0]  m, s, t, d, sh;
        logic [15:0] im;
        logic [25:0] tg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: returns {legal, word} from the mnemonic table and field rules
    function automatic logic [32:0] ref_encode(input logic [4:0] m, s, t, d, sh,
                                                input logic [15:0] im, input logic [25:0] tg);
        int     mi = int'(m);
        logic [4:0] ks, kt, kd, ksh;
        bit     dropped;
        bit     check_en;
`ifdef MIPS_ENC_FIELD_CHECK_EN
        check_en = 1;
`else
        check_en = 0;
`endif
        if (mi == 31) return 33'd0;
        if (mi <= 16) begin
            ks  = (mi >= 10 && mi <= 12) ? 5'd0 : s;
            kt  = (mi == 16) ? 5'd0 : t;
            kd  = (mi == 16) ? 5'd0 : d;
            ksh = (mi >= 10 && mi <= 12) ? sh : 5'd0;
            dropped = (ks != s) || (kt != t) || (kd != d) || (ksh != sh) || im != 0 || tg != 0;
            return {!(check_en && dropped), 6'h00, ks, kt, kd, ksh, FUNCT_TAB[mi]};
        end
        if (mi <= 28) begin
            ks = (mi == 24) ? 5'd0 : s;
            dropped = (ks != s) || d != 0 || sh != 0 || tg != 0;
            return {!(check_en && dropped), OP_TAB[mi-17], ks, t, im};
        end
        dropped = s != 0 || t != 0 || d != 0 || sh != 0 || im != 0;
        return {!(check_en && dropped), OP_TAB[mi-17], tg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input logic [4:0] m, s, t, d, sh, input logic [15:0] im,
                           input logic [25:0] tg);
        in_valid = 1'b1; mnem = m; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Randomized traffic against a queue model
    task automatic random_phase(input int cycles);
        logic [31:0] q[$];
        logic [32:0] enc;
        int          m_cnt = 0;
        bit          m_err = 0;
        bit          acc, pop;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd_out_instr", out_instr, (q.size() != 0) ? q[0] : 32'd0);
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("rnd_err", 32'(err), 32'(m_err));
            chk("rnd_emit_cnt", 32'(emit_cnt), 32'(m_cnt % (1 << CNT_W)));
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            mnem   = ($urandom_range(0, 40) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            rs     = $urandom_range(0, 1) ? 5'($urandom) : 5'd0;
            rt     = $urandom_range(0, 1) ? 5'($urandom) : 5'd0;
            rd     = $urandom_range(0, 1) ? 5'($urandom) : 5'd0;
            shamt  = $urandom_range(0, 1) ? 5'($urandom) : 5'd0;
            imm    = $urandom_range(0, 1) ? 16'($urandom) : 16'd0;
            target = $urandom_range(0, 1) ? 26'($urandom) : 26'd0;
            enc = ref_encode(mnem, rs, rt, rd, shamt, imm, target);
            acc = in_valid && (q.size() < DEPTH);
            pop = out_ready && (q.size() != 0);
            if (pop) begin
                void'(q.pop_front());
                m_cnt++;
            end
            if (acc) begin
                if (enc[32]) q.push_back(enc[31:0]);
                else m_err = 1;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mnem = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;

        // Reset state
        do_reset();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_instr", out_instr, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_emit_cnt", 32'(emit_cnt), 32'd0);

        // Single-word vectors: push into an empty FIFO, check head, pop
        vecs.push_back('{5'd0,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0000, 26'h0,       32'h00221820});
        vecs.push_back('{5'd25, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0,       32'h8FA80004});
        vecs.push_back('{5'd24, 5'd0,  5'd5, 5'd0, 5'd0, 16'h1234, 26'h0,       32'h3C051234});
        vecs.push_back('{5'd10, 5'd0,  5'd3, 5'd2, 5'd4, 16'h0000, 26'h0,       32'h00031100});
        vecs.push_back('{5'd12, 5'd0,  5'd3, 5'd2, 5'd4, 16'h0000, 26'h0,       32'h00031103});
        vecs.push_back('{5'd29, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0000, 26'h0100000, 32'h08100000});
        vecs.push_back('{5'd30, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF});
        vecs.push_back('{5'd16, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0,       32'h03E00008});
        vecs.push_back('{5'd27, 5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0,       32'h1022FFFF});
        vecs.push_back('{5'd13, 5'd4,  5'd5, 5'd6, 5'd0, 16'h0000, 26'h0,       32'h00853004});
        vecs.push_back('{5'd7,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0000, 26'h0,       32'h00221827});
        for (int k = 0; k < vecs.size(); k++) begin
            set_req(vecs[k].m, vecs[k].s, vecs[k].t, vecs[k].d, vecs[k].sh, vecs[k].im, vecs[k].tg);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_instr", k), out_instr, vecs[k].exp);
            pop_one();
            chk($sformatf("vec%0d_emit_cnt", k), 32'(emit_cnt), 32'(k + 1));
            chk($sformatf("vec%0d_empty", k), 32'(out_valid), 32'd0);
        end

        // Two back-to-back words emerge in order
        set_req(5'd25, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0); tick();
        set_req(5'd24, 5'd0, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0); tick();
        in_valid = 1'b0;
        chk("order_first", out_instr, 32'h8FA80004);
        pop_one();
        chk("order_second", out_instr, 32'h3C051234);
        pop_one();

        // Backpressure: fill FIFO, hold the fifth, one pop admits it next cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'(i), 26'h0);
            chk($sformatf("fill%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
        end
        set_req(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'd4, 26'h0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("full_hold_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_instr, 32'h20000000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("fifth_in_ready", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain%0d", i), out_instr, 32'h20000000 | 32'(i));
            pop_one();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_emit_cnt", 32'(emit_cnt), 32'd5);

        // Illegal mnemonic: handshake completes, nothing enqueued, err sticks
        do_reset();
        set_req(5'd31, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        chk("illegal_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("illegal_out_valid", 32'(out_valid), 32'd0);
        chk("illegal_err", 32'(err), 32'd1);
        tick(); tick();
        chk("illegal_err_sticky", 32'(err), 32'd1);

        // Ignored nonzero field on an I-type request
        do_reset();
        set_req(5'd17, 5'd1, 5'd2, 5'd7, 5'd0, 16'h0005, 26'h0);
        tick();
        in_valid = 1'b0;
`ifdef MIPS_ENC_FIELD_CHECK_EN
        chk("fieldchk_out_valid", 32'(out_valid), 32'd0);
        chk("fieldchk_err", 32'(err), 32'd1);
`else
        chk("fieldchk_instr", out_instr, 32'h20220005);
        chk("fieldchk_err", 32'(err), 32'd0);
`endif

        // Reset mid-stream with three words buffered, nonzero count and err
        do_reset();
        set_req(5'd18, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0); tick();
        in_valid = 1'b0;
        pop_one();
        set_req(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0); tick();
        for (int i = 0; i < 3; i++) begin
            set_req(5'd18, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'h0); tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_emit_cnt", 32'(emit_cnt), 32'd1);
        chk("pre_rst_err", 32'(err), 32'd1);
        do_reset();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_instr", out_instr, 32'd0);
        chk("midrst_emit_cnt", 32'(emit_cnt), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);

        random_phase(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
